// File: rtl/power_decode_bundle.sv
// Multi-lane Power ISA decode stage: format classification, field slicing, I-form targets.
// Latency: one cycle, bundle accepted on enable_i & ~stall_i & ~flush_i is visible after the edge.
// Backpressure: stall_i holds every output bit-stable; ready_o = ~stall_i, flush_i overrides stall_i.
module power_decode_bundle #(
   parameter int laneCount        = 2,
   parameter int instructionWidth = 32,
   parameter int addressSize      = 64,
   parameter int formatWidth      = 5
) (
   input  logic                                  clock_i,
   input  logic                                  reset_i,
   input  logic                                  enable_i,
   input  logic                                  flush_i,
   input  logic                                  stall_i,
   output logic                                  ready_o,
   input  logic [laneCount-1:0]                  instValid_i,
   input  logic [laneCount*instructionWidth-1:0] instruction_i,
   input  logic [addressSize-1:0]                instructionAddress_i,
   output logic [laneCount-1:0]                  decodeValid_o,
   output logic [laneCount-1:0]                  illegal_o,
   output logic [laneCount*formatWidth-1:0]      format_o,
   output logic [laneCount*6-1:0]                opcode_o,
   output logic [laneCount*5-1:0]                rt_o,
   output logic [laneCount*5-1:0]                ra_o,
   output logic [laneCount*5-1:0]                rb_o,
   output logic [laneCount*16-1:0]               imm_o,
   output logic [laneCount*10-1:0]               xOpcode_o,
   output logic [laneCount-1:0]                  rc_o,
   output logic [laneCount*addressSize-1:0]      address_o,
   output logic [laneCount*addressSize-1:0]      branchTarget_o
);

   localparam logic [formatWidth-1:0] FMT_INVALID = formatWidth'(0);
   localparam logic [formatWidth-1:0] FMT_D       = formatWidth'(3);
   localparam logic [formatWidth-1:0] FMT_DS      = formatWidth'(5);
   localparam logic [formatWidth-1:0] FMT_I       = formatWidth'(7);
   localparam logic [formatWidth-1:0] FMT_M       = formatWidth'(8);
   localparam logic [formatWidth-1:0] FMT_MD      = formatWidth'(9);
   localparam logic [formatWidth-1:0] FMT_MDS     = formatWidth'(10);
   localparam logic [formatWidth-1:0] FMT_SC      = formatWidth'(11);
   localparam logic [formatWidth-1:0] FMT_X       = formatWidth'(15);
   localparam logic [formatWidth-1:0] FMT_XFX     = formatWidth'(17);
   localparam logic [formatWidth-1:0] FMT_XL      = formatWidth'(18);
   localparam logic [formatWidth-1:0] FMT_XO      = formatWidth'(19);
   localparam logic [formatWidth-1:0] FMT_B       = formatWidth'(26);

   // Big-endian bit k of the instruction word is Verilog bit 31-k.
   function automatic logic [formatWidth-1:0] classify(input logic [31:0] ins);
      logic [5:0]             op;
      logic [formatWidth-1:0] fmt;
      op  = ins[31:26];
      fmt = FMT_INVALID;
      if (op == 6'd18)      fmt = FMT_I;
      else if (op == 6'd16) fmt = FMT_B;
      else if (op == 6'd17) fmt = FMT_SC;
      else if (op == 6'd19) fmt = FMT_XL;
      else if (op inside {6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29], [6'd32:6'd47]}) fmt = FMT_D;
      else if (op inside {6'd58, 6'd62}) fmt = FMT_DS;
      else if (op inside {6'd20, 6'd21, 6'd23}) fmt = FMT_M;
      else if (op == 6'd30) begin
         if (!ins[4])                                fmt = FMT_MD;
         else if (ins[4:1] inside {4'd8, 4'd9})      fmt = FMT_MDS;
      end else if (op == 6'd31) begin
         if (ins[9:1] inside {9'd8, 9'd10, 9'd40, 9'd104, 9'd235, 9'd266})  fmt = FMT_XO;
         else if (ins[10:1] inside {10'd19, 10'd144, 10'd339, 10'd467})    fmt = FMT_XFX;
         else if (ins[10:2] == 9'd413)                                     fmt = FMT_XS_OR_X(1'b1);
         else                                                              fmt = FMT_X;
      end
      return fmt;
   endfunction

   // XS is split out so the 21-29 compare stays readable above.
   function automatic logic [formatWidth-1:0] FMT_XS_OR_X(input logic isXs);
      return isXs ? formatWidth'(20) : FMT_X;
   endfunction

   logic [laneCount-1:0]                  laneIllegal;
   logic [laneCount-1:0]                  valid_d,   valid_q;
   logic [laneCount-1:0]                  illegal_d, illegal_q;
   logic [laneCount*formatWidth-1:0]      format_d,  format_q;
   logic [laneCount*6-1:0]                opcode_d,  opcode_q;
   logic [laneCount*5-1:0]                rt_d, rt_q, ra_d, ra_q, rb_d, rb_q;
   logic [laneCount*16-1:0]               imm_d,     imm_q;
   logic [laneCount*10-1:0]               xop_d,     xop_q;
   logic [laneCount-1:0]                  rc_d,      rc_q;
   logic [laneCount*addressSize-1:0]      addr_d,    addr_q;
   logic [laneCount*addressSize-1:0]      target_d,  target_q;

   for (genvar k = 0; k < laneCount; k++) begin : g_lane
      logic [31:0]             ins;
      logic [formatWidth-1:0]  fmt;
      logic [addressSize-1:0]  laneAddr;
      logic [addressSize-1:0]  offset;
      assign ins      = instruction_i[k*instructionWidth +: 32];
      assign fmt      = classify(ins);
      assign laneAddr = instructionAddress_i + addressSize'(4 * k);
      // LI || 00, sign-extended from bit 25 of the word.
      assign offset   = {{(addressSize-26){ins[25]}}, ins[25:2], 2'b00};

      assign laneIllegal[k]                          = (fmt == FMT_INVALID);
      assign format_d[k*formatWidth +: formatWidth]  = fmt;
      assign opcode_d[k*6 +: 6]                      = ins[31:26];
      assign rt_d[k*5 +: 5]                          = ins[25:21];
      assign ra_d[k*5 +: 5]                          = ins[20:16];
      assign rb_d[k*5 +: 5]                          = ins[15:11];
      assign imm_d[k*16 +: 16]                       = ins[15:0];
      assign xop_d[k*10 +: 10]                       = ins[10:1];
      assign rc_d[k]                                 = ins[0];
      assign addr_d[k*addressSize +: addressSize]    = laneAddr;
      assign target_d[k*addressSize +: addressSize]  = (fmt != FMT_I) ? '0 :
                                                       (ins[1] ? offset : laneAddr + offset);
   end

   // Program-order kill: the first valid illegal lane suppresses every later lane.
   always_comb begin
      logic killSeen;
      killSeen  = 1'b0;
      valid_d   = '0;
      illegal_d = '0;
      for (int k = 0; k < laneCount; k++) begin
         valid_d[k]   = instValid_i[k] & ~killSeen;
         illegal_d[k] = valid_d[k] & laneIllegal[k];
         killSeen     = killSeen | illegal_d[k];
      end
   end

   // Pipeline register: reset > flush > stall > load > bubble.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         valid_q   <= '0;
         illegal_q <= '0;
         format_q  <= '0;
         opcode_q  <= '0;
         rt_q      <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         imm_q     <= '0;
         xop_q     <= '0;
         rc_q      <= '0;
         addr_q    <= '0;
         target_q  <= '0;
      end else if (flush_i) begin
         valid_q   <= '0;
         illegal_q <= '0;
      end else if (stall_i) begin
         valid_q   <= valid_q;
         illegal_q <= illegal_q;
      end else if (enable_i) begin
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         format_q  <= format_d;
         opcode_q  <= opcode_d;
         rt_q      <= rt_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         imm_q     <= imm_d;
         xop_q     <= xop_d;
         rc_q      <= rc_d;
         addr_q    <= addr_d;
         target_q  <= target_d;
      end else begin
         valid_q   <= '0;
         illegal_q <= '0;
      end
   end

   assign ready_o        = ~stall_i;
   assign decodeValid_o  = valid_q;
   assign illegal_o      = illegal_q;
   assign format_o       = format_q;
   assign opcode_o       = opcode_q;
   assign rt_o           = rt_q;
   assign ra_o           = ra_q;
   assign rb_o           = rb_q;
   assign imm_o          = imm_q;
   assign xOpcode_o      = xop_q;
   assign rc_o           = rc_q;
   assign address_o      = addr_q;
   assign branchTarget_o = target_q;

endmodule

// File: tb/tb_power_decode_bundle.sv
// Bench for power_decode_bundle: spec-level model plus directed literal vectors.
// Latency: model result of edge n compared at the following falling edge.
// Backpressure: stall/flush/reset priority exercised directly and in a random control mix.
module tb_power_decode_bundle;
   localparam int L = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_i, enable_i, flush_i, stall_i, ready_o;
   logic [L-1:0]    instValid_i, decodeValid_o, illegal_o, rc_o;
   logic [L*32-1:0] instruction_i;
   logic [63:0]     instructionAddress_i;
   logic [L*5-1:0]  format_o, rt_o, ra_o, rb_o;
   logic [L*6-1:0]  opcode_o;
   logic [L*16-1:0] imm_o;
   logic [L*10-1:0] xOpcode_o;
   logic [L*64-1:0] address_o, branchTarget_o;

   power_decode_bundle #(.laneCount(L)) dut (
      .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .flush_i(flush_i),
      .stall_i(stall_i), .ready_o(ready_o), .instValid_i(instValid_i),
      .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
      .decodeValid_o(decodeValid_o), .illegal_o(illegal_o), .format_o(format_o),
      .opcode_o(opcode_o), .rt_o(rt_o), .ra_o(ra_o), .rb_o(rb_o), .imm_o(imm_o),
      .xOpcode_o(xOpcode_o), .rc_o(rc_o), .address_o(address_o),
      .branchTarget_o(branchTarget_o)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input int ln, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s lane%0d actual=%h expected=%h at %0t", nm, ln, act, exp, $time);
      end
   endtask

   // Big-endian field [a:b] of a 32-bit word.
   function automatic logic [63:0] fld(input logic [31:0] w, input int a, input int b);
      return (64'(w) >> (31 - b)) & ((64'd1 << (b - a + 1)) - 64'd1);
   endfunction

   function automatic int fmt_of(input logic [31:0] w);
      int op;
      op = int'(fld(w, 0, 5));
      if (op == 18) return 7;
      if (op == 16) return 26;
      if (op == 17) return 11;
      if (op == 19) return 18;
      if (op == 7 || op == 8 || (op >= 10 && op <= 15) || (op >= 24 && op <= 29) ||
          (op >= 32 && op <= 47)) return 3;
      if (op == 58 || op == 62) return 5;
      if (op == 20 || op == 21 || op == 23) return 8;
      if (op == 30) begin
         if (fld(w, 27, 27) == 0) return 9;
         if (fld(w, 27, 30) == 8 || fld(w, 27, 30) == 9) return 10;
         return 0;
      end
      if (op == 31) begin
         case (int'(fld(w, 22, 30)))
            8, 10, 40, 104, 235, 266: return 19;
            default: ;
         endcase
         case (int'(fld(w, 21, 30)))
            19, 144, 339, 467: return 17;
            default: ;
         endcase
         if (fld(w, 21, 29) == 413) return 20;
         return 15;
      end
      return 0;
   endfunction

   // Model of the registered outputs.
   bit          mv [L], mi [L], mk [L];
   bit          m_rst = 1'b0;
   logic [63:0] mfmt [L], mop [L], mrt [L], mra [L], mrb [L], mimm [L], mxo [L], mrc [L],
                maddr [L], mtgt [L];

   always @(posedge clk) begin
      if (reset_i) begin
         m_rst = 1'b1;
         for (int k = 0; k < L; k++) begin
            mv[k] = 0; mi[k] = 0; mk[k] = 0;
            mfmt[k] = 0; mop[k] = 0; mrt[k] = 0; mra[k] = 0; mrb[k] = 0;
            mimm[k] = 0; mxo[k] = 0; mrc[k] = 0; maddr[k] = 0; mtgt[k] = 0;
         end
      end else if (flush_i) begin
         m_rst = 1'b0;
         for (int k = 0; k < L; k++) begin mv[k] = 0; mi[k] = 0; mk[k] = 0; end
      end else if (stall_i) begin
         m_rst = m_rst;
      end else if (enable_i) begin
         bit kill;
         kill  = 0;
         m_rst = 1'b0;
         for (int k = 0; k < L; k++) begin
            logic [31:0] w;
            logic [63:0] li, off;
            int          f;
            w        = instruction_i[32*k +: 32];
            f        = fmt_of(w);
            maddr[k] = instructionAddress_i + 64'(4 * k);
            mk[k]    = kill && instValid_i[k];
            mv[k]    = instValid_i[k] && !kill;
            mi[k]    = mv[k] && (f == 0);
            if (mi[k]) kill = 1;
            mfmt[k] = 64'(f);
            mop[k]  = fld(w, 0, 5);
            mrt[k]  = fld(w, 6, 10);
            mra[k]  = fld(w, 11, 15);
            mrb[k]  = fld(w, 16, 20);
            mimm[k] = fld(w, 16, 31);
            mxo[k]  = fld(w, 21, 30);
            mrc[k]  = fld(w, 31, 31);
            li      = fld(w, 6, 29);
            off     = li << 2;
            if (li[23]) off = off | ~64'h3FF_FFFF;
            if (f != 7)                mtgt[k] = 0;
            else if (fld(w, 30, 30))   mtgt[k] = off;
            else                       mtgt[k] = maddr[k] + off;
         end
      end else begin
         m_rst = 1'b0;
         for (int k = 0; k < L; k++) begin mv[k] = 0; mi[k] = 0; mk[k] = 0; end
      end
   end

   // Every falling edge: DUT against model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("ready", 0, 64'(ready_o), 64'(!stall_i));
         for (int k = 0; k < L; k++) begin
            cmp("valid", k, 64'(decodeValid_o[k]), 64'(mv[k]));
            if (!mk[k]) cmp("illegal", k, 64'(illegal_o[k]), 64'(mi[k]));
            if (mv[k] || m_rst) begin
               cmp("format", k, 64'(format_o[5*k +: 5]), mfmt[k]);
               cmp("opcode", k, 64'(opcode_o[6*k +: 6]), mop[k]);
               cmp("rt",     k, 64'(rt_o[5*k +: 5]), mrt[k]);
               cmp("ra",     k, 64'(ra_o[5*k +: 5]), mra[k]);
               cmp("rb",     k, 64'(rb_o[5*k +: 5]), mrb[k]);
               cmp("imm",    k, 64'(imm_o[16*k +: 16]), mimm[k]);
               cmp("xop",    k, 64'(xOpcode_o[10*k +: 10]), mxo[k]);
               cmp("rc",     k, 64'(rc_o[k]), mrc[k]);
               cmp("address", k, address_o[64*k +: 64], maddr[k]);
               cmp("target", k, branchTarget_o[64*k +: 64], mtgt[k]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [63:0] base);
      instValid_i          = v;
      instruction_i        = {w1, w0};
      instructionAddress_i = base;
   endtask

   logic [31:0] pool [20] = '{
      32'h38610005, 32'h7C642A14, 32'h48000100, 32'h4BFFFFFD, 32'h48000102, 32'h04000000,
      32'h7C6802A6, 32'h7C600674, 32'h41820010, 32'h44000002, 32'h78630020, 32'h78630010,
      32'h78630018, 32'hE8630008, 32'h5463103A, 32'h7C632378, 32'h4C000020, 32'hFC000000,
      32'h4BFFFF00, 32'h80830004};

   initial begin
      reset_i = 1; enable_i = 0; flush_i = 0; stall_i = 0;
      drive(2'b00, 0, 0, 0);
      // Reset with random inputs on every other port.
      repeat (3) begin
         enable_i = 1'($urandom); flush_i = 1'($urandom); stall_i = 1'($urandom);
         drive(2'($urandom), $urandom, $urandom, {$urandom, $urandom});
         tick();
         chk_en = 1'b1;
         cmp("rst_valid", 0, 64'(decodeValid_o), 64'd0);
         cmp("rst_illegal", 0, 64'(illegal_o), 64'd0);
         cmp("rst_address", 1, address_o[127:64], 64'd0);
         cmp("rst_ready", 0, 64'(ready_o), 64'(!stall_i));
      end
      reset_i = 0; flush_i = 0; stall_i = 0; enable_i = 1;

      // D / XO
      drive(2'b11, 32'h38610005, 32'h7C642A14, 64'h1000);
      tick();
      cmp("d_fmt", 0, 64'(format_o[4:0]), 64'd3);
      cmp("d_op", 0, 64'(opcode_o[5:0]), 64'd14);
      cmp("d_rt", 0, 64'(rt_o[4:0]), 64'd3);
      cmp("d_ra", 0, 64'(ra_o[4:0]), 64'd1);
      cmp("d_imm", 0, 64'(imm_o[15:0]), 64'd5);
      cmp("d_addr", 0, address_o[63:0], 64'h1000);
      cmp("xo_fmt", 1, 64'(format_o[9:5]), 64'd19);
      cmp("xo_op", 1, 64'(opcode_o[11:6]), 64'd31);
      cmp("xo_rb", 1, 64'(rb_o[9:5]), 64'd5);
      cmp("xo_xop", 1, 64'(xOpcode_o[19:10]), 64'd266);
      cmp("xo_addr", 1, address_o[127:64], 64'h1004);
      cmp("model_fmt", 1, mfmt[1], 64'd19);

      // Branch targets
      drive(2'b11, 32'h48000100, 32'h4BFFFFFD, 64'h2000);
      tick();
      cmp("br_tgt", 0, branchTarget_o[63:0], 64'h2100);
      cmp("br_tgt", 1, branchTarget_o[127:64], 64'h2000);
      cmp("br_rc", 1, 64'(rc_o[1]), 64'd1);
      cmp("model_tgt", 1, mtgt[1], 64'h2000);
      drive(2'b11, 32'h48000102, 32'h4BFFFFFD, 64'h2000);
      tick();
      cmp("br_aa_tgt", 0, branchTarget_o[63:0], 64'h100);

      // Illegal kill
      drive(2'b11, 32'h04000000, 32'h38610005, 64'h3000);
      tick();
      cmp("kill_valid", 0, 64'(decodeValid_o), 64'b01);
      cmp("kill_illegal", 0, 64'(illegal_o[0]), 64'd1);
      cmp("kill_fmt", 0, 64'(format_o[4:0]), 64'd0);

      // Assorted formats through the model, including a gated lane0
      drive(2'b11, 32'h7C6802A6, 32'h7C600674, 64'h4000); tick();
      cmp("xfx_fmt", 0, 64'(format_o[4:0]), 64'd17);
      cmp("xs_fmt", 1, 64'(format_o[9:5]), 64'd20);
      drive(2'b11, 32'h78630020, 32'h78630010, 64'h4100); tick();
      cmp("md_fmt", 0, 64'(format_o[4:0]), 64'd9);
      cmp("mds_fmt", 1, 64'(format_o[9:5]), 64'd10);
      drive(2'b10, 32'h04000000, 32'h78630018, 64'h4200); tick();
      cmp("gated_valid", 0, 64'(decodeValid_o), 64'b10);
      drive(2'b11, 32'h41820010, 32'hE8630008, 64'h4300); tick();
      cmp("b_tgt", 0, branchTarget_o[63:0], 64'd0);

      // Stall for three cycles with changing inputs, then flush under stall
      drive(2'b11, 32'h38610005, 32'h7C642A14, 64'h1000); tick();
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, pool[i * 3], pool[i * 3 + 1], 64'h9000 + 64'(i));
         tick();
         cmp("stall_ready", i, 64'(ready_o), 64'd0);
         cmp("stall_fmt", 1, 64'(format_o[9:5]), 64'd19);
         cmp("stall_addr", 1, address_o[127:64], 64'h1004);
      end
      flush_i = 1; tick();
      cmp("flush_valid", 0, 64'(decodeValid_o), 64'd0);
      cmp("flush_ready", 0, 64'(ready_o), 64'd0);
      flush_i = 0; stall_i = 0;

      // Bubble and wrap-around
      drive(2'b11, 32'h38610005, 32'h48000010, 64'h5000); tick();
      enable_i = 0; tick();
      cmp("bubble_valid", 0, 64'(decodeValid_o), 64'd0);
      enable_i = 1;
      drive(2'b11, 32'h38610005, 32'h48000010, 64'hFFFF_FFFF_FFFF_FFFC); tick();
      cmp("wrap_addr", 0, address_o[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
      cmp("wrap_addr", 1, address_o[127:64], 64'h0);
      cmp("wrap_tgt", 1, branchTarget_o[127:64], 64'h10);

      // Reset wins over stall and flush
      stall_i = 1; flush_i = 1; reset_i = 1; tick();
      cmp("rst_stall_addr", 0, address_o[63:0], 64'd0);
      cmp("rst_stall_valid", 0, 64'(decodeValid_o), 64'd0);
      reset_i = 0; flush_i = 0; stall_i = 0;

      // Mixed controls over the instruction pool
      for (int i = 0; i < 80; i++) begin
         reset_i  = ($urandom_range(0, 31) == 0);
         flush_i  = ($urandom_range(0, 7) == 0);
         stall_i  = ($urandom_range(0, 3) == 0);
         enable_i = ($urandom_range(0, 3) != 0);
         drive(2'($urandom), pool[$urandom_range(0, 19)], pool[$urandom_range(0, 19)],
               {$urandom, $urandom});
         tick();
      end
      reset_i = 0; flush_i = 0; stall_i = 0; enable_i = 0;
      tick();
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
